// File: rtl/mips_mdu.sv
// -----------------------------------------------------------------------------
// mips_mdu : multi-cycle multiply/divide unit with HI/LO registers.
//
// Ops are issued with a one-cycle in_start strobe while the unit is idle.
// mthi/mtlo write HI/LO immediately. mult/multu/div/divu (and madd/maddu when
// enabled) compute the full result at the accepting edge into a pending
// register. HI/LO only change after a fixed number of busy cycles.
//
// Optional feature macro: MIPS_MDU_MADD_EN
//   defined     -> ops 110/111 (madd/maddu) accumulate into {HI,LO}
//   not defined -> ops 110/111 are no-ops and no accumulate adder is built
//
// Parameters:
//   WIDTH        operand width and HI/LO width
//   MULT_CYCLES  busy cycles for mult/multu/madd/maddu (>=1)
//   DIV_CYCLES   busy cycles for div/divu (>=1)
//
// Ports:
//   clk       system clock, rising edge
//   reset     synchronous active-high reset; aborts any op in flight
//   in_start  issue strobe, accepted only while out_busy=0
//   in_op     000 mult, 001 multu, 010 div, 011 divu,
//             100 mthi, 101 mtlo, 110 madd, 111 maddu
//   in_a      rs operand
//   in_b      rt operand
//   out_busy  registered, high while a multi-cycle op is in flight
//   out_hi    HI register
//   out_lo    LO register
// -----------------------------------------------------------------------------
module mips_mdu #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_start,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_busy,
  output logic [WIDTH-1:0] out_hi,
  output logic [WIDTH-1:0] out_lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
`ifdef MIPS_MDU_MADD_EN
  localparam logic [2:0] OP_MADD  = 3'b110;
  localparam logic [2:0] OP_MADDU = 3'b111;
`endif

  localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONE = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [CW-1:0]      counter_reg;
  logic               busy_reg;
  logic               commit_reg;   // clear when the result must be discarded (divide by zero)
  logic [2*WIDTH-1:0] pending_reg;
  logic [WIDTH-1:0]   hi_reg;
  logic [WIDTH-1:0]   lo_reg;

  logic               accept;
  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] prod_u;
  logic [WIDTH-1:0]   divisor;
  logic [WIDTH-1:0]   quo_s;
  logic [WIDTH-1:0]   rem_s;
  logic [WIDTH-1:0]   quo_u;
  logic [WIDTH-1:0]   rem_u;
  logic               div_ovf;

  assign accept = in_start && !busy_reg;

  // Full-width products and quotients, computed from the live operands so the
  // result is captured at the accepting edge.
  always_comb begin
    prod_s  = $signed({{WIDTH{in_a[WIDTH-1]}}, in_a}) *
              $signed({{WIDTH{in_b[WIDTH-1]}}, in_b});
    prod_u  = {{WIDTH{1'b0}}, in_a} * {{WIDTH{1'b0}}, in_b};
    // Divide by zero never commits; substitute 1 so the divider sees a
    // defined operand.
    divisor = (in_b == '0) ? ONE : in_b;
    div_ovf = (in_a == MIN_INT) && (in_b == ALL_ONE);
    quo_s   = $signed(in_a) / $signed(divisor);
    rem_s   = $signed(in_a) % $signed(divisor);
    // MIN_INT / -1 overflows the quotient; pin the architectural result.
    if (div_ovf) begin
      quo_s = MIN_INT;
      rem_s = '0;
    end
    quo_u   = in_a / divisor;
    rem_u   = in_a % divisor;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      counter_reg <= '0;
      busy_reg    <= 1'b0;
      commit_reg  <= 1'b0;
      pending_reg <= '0;
      hi_reg      <= '0;
      lo_reg      <= '0;
    end else if (busy_reg) begin
      // Busy always mirrors (counter != 0); it drops on the 1->0 edge
      // together with the HI/LO update.
      counter_reg <= counter_reg - CNT_ONE;
      if (counter_reg == CNT_ONE) begin
        busy_reg <= 1'b0;
        if (commit_reg) begin
          {hi_reg, lo_reg} <= pending_reg;
        end
      end
    end else if (accept) begin
      case (in_op)
        OP_MTHI: hi_reg <= in_a;
        OP_MTLO: lo_reg <= in_a;
        OP_MULT: begin
          pending_reg <= prod_s;
          commit_reg  <= 1'b1;
          counter_reg <= MULT_LOAD;
          busy_reg    <= 1'b1;
        end
        OP_MULTU: begin
          pending_reg <= prod_u;
          commit_reg  <= 1'b1;
          counter_reg <= MULT_LOAD;
          busy_reg    <= 1'b1;
        end
        OP_DIV: begin
          pending_reg <= {rem_s, quo_s};
          commit_reg  <= (in_b != '0);
          counter_reg <= DIV_LOAD;
          busy_reg    <= 1'b1;
        end
        OP_DIVU: begin
          pending_reg <= {rem_u, quo_u};
          commit_reg  <= (in_b != '0);
          counter_reg <= DIV_LOAD;
          busy_reg    <= 1'b1;
        end
`ifdef MIPS_MDU_MADD_EN
        // Accumulator value is the {HI,LO} seen at the accepting edge.
        OP_MADD: begin
          pending_reg <= {hi_reg, lo_reg} + prod_s;
          commit_reg  <= 1'b1;
          counter_reg <= MULT_LOAD;
          busy_reg    <= 1'b1;
        end
        OP_MADDU: begin
          pending_reg <= {hi_reg, lo_reg} + prod_u;
          commit_reg  <= 1'b1;
          counter_reg <= MULT_LOAD;
          busy_reg    <= 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  assign out_busy = busy_reg;
  assign out_hi   = hi_reg;
  assign out_lo   = lo_reg;

endmodule

// File: tb/tb_mips_mdu.sv
// -----------------------------------------------------------------------------
// tb_mips_mdu : self-checking bench for mips_mdu (WIDTH=32, 5/10 cycles).
// A behavioural model tracks HI/LO and the cycle at which the in-flight op
// completes; a negedge process compares busy/HI/LO every cycle. Directed
// sequences pin the model with literal values, then random ops follow.
// -----------------------------------------------------------------------------
module tb_mips_mdu;

  localparam int W  = 32;
  localparam int MC = 5;
  localparam int DC = 10;

  logic          clk;
  logic          reset;
  logic          in_start;
  logic [2:0]    in_op;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          out_busy;
  logic [W-1:0]  out_hi;
  logic [W-1:0]  out_lo;

  mips_mdu #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_start (in_start),
    .in_op    (in_op),
    .in_a     (in_a),
    .in_b     (in_b),
    .out_busy (out_busy),
    .out_hi   (out_hi),
    .out_lo   (out_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: architectural HI/LO, the edge index at which the current op
  // completes, and the result it will deliver.
  longint       cyc      = 0;
  longint       done_at  = 0;
  logic [63:0]  pend     = '0;
  bit           pend_ok  = 0;
  logic [W-1:0] exp_hi   = '0;
  logic [W-1:0] exp_lo   = '0;
  bit           exp_busy = 0;
  bit           model_live = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [63:0] op_result(input logic [2:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b,
                                            input logic [63:0] acc);
    longint sa, sb, q, r;
    logic [63:0] ua, ub, res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    res = '0;
    case (op)
      3'b000: res = 64'(sa * sb);
      3'b001: res = ua * ub;
      3'b010: begin
        q = sa / sb;   // 64-bit arithmetic: MIN_INT / -1 lands on 2^31
        r = sa % sb;
        res = {r[31:0], q[31:0]};
      end
      3'b011: begin
        q = longint'(ua / ub);
        r = longint'(ua % ub);
        res = {r[31:0], q[31:0]};
      end
      3'b110: res = acc + 64'(sa * sb);
      3'b111: res = acc + ua * ub;
      default: res = '0;
    endcase
    return res;
  endfunction

  // Advance the model by one rising edge using the inputs presented to it.
  task automatic model_edge();
    bit busy_before;
    cyc++;
    if (reset) begin
      exp_hi  = '0;
      exp_lo  = '0;
      done_at = 0;
      pend_ok = 0;
    end else begin
      busy_before = (cyc <= done_at);
      if (cyc == done_at && pend_ok) {exp_hi, exp_lo} = pend;
      if (in_start && !busy_before) begin
        case (in_op)
          3'b100: exp_hi = in_a;
          3'b101: exp_lo = in_a;
          3'b000, 3'b001: begin
            pend = op_result(in_op, in_a, in_b, '0); pend_ok = 1; done_at = cyc + MC;
          end
          3'b010, 3'b011: begin
            pend_ok = (in_b != 0);
            if (pend_ok) pend = op_result(in_op, in_a, in_b, '0);
            done_at = cyc + DC;
          end
`ifdef MIPS_MDU_MADD_EN
          3'b110, 3'b111: begin
            pend = op_result(in_op, in_a, in_b, {exp_hi, exp_lo}); pend_ok = 1; done_at = cyc + MC;
          end
`endif
          default: ;
        endcase
      end
    end
    exp_busy = (cyc < done_at);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (model_live) begin
      check("busy", {31'b0, out_busy}, {31'b0, exp_busy});
      check("hi", out_hi, exp_hi);
      check("lo", out_lo, exp_lo);
    end
  end

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    in_start = 1'b1; in_op = op; in_a = a; in_b = b;
    tick();
    in_start = 1'b0;
  endtask

  // Counts busy cycles after an accept, bounded.
  task automatic wait_idle(output int n);
    n = 1;
    while (out_busy && n < 60) begin
      tick();
      if (out_busy) n++;
    end
    if (out_busy) check("idle_timeout", {31'b0, out_busy}, '0);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return W'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  int n;

  initial begin
    reset = 1'b1; in_start = 1'b0; in_op = '0; in_a = '0; in_b = '0;
    tick();
    model_live = 1;
    tick();
    check("rst_busy", {31'b0, out_busy}, '0);
    check("rst_hi", out_hi, '0);
    check("rst_lo", out_lo, '0);
    reset = 1'b0;
    tick();

    // mult -3 * 7
    issue(3'b000, 32'hFFFF_FFFD, 32'd7);
    wait_idle(n);
    check("mult_busy_cycles", W'(n), W'(MC));
    check("mult_hi", out_hi, 32'hFFFF_FFFF);
    check("mult_lo", out_lo, 32'hFFFF_FFEB);
    tick();

    // div -7 / 2, then divu by zero leaves HI/LO alone
    issue(3'b010, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    check("div_busy_cycles", W'(n), W'(DC));
    check("div_lo", out_lo, 32'hFFFF_FFFD);
    check("div_hi", out_hi, 32'hFFFF_FFFF);
    tick();
    issue(3'b011, 32'd7, 32'd0);
    wait_idle(n);
    check("divz_busy_cycles", W'(n), W'(DC));
    check("divz_hi", out_hi, 32'hFFFF_FFFF);
    check("divz_lo", out_lo, 32'hFFFF_FFFD);
    tick();

    // MIN_INT / -1
    issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    check("ovf_lo", out_lo, 32'h8000_0000);
    check("ovf_hi", out_hi, 32'h0);
    tick();

    // mthi then mtlo back to back
    issue(3'b100, 32'h1234_5678, 32'h0);
    check("mthi_busy", {31'b0, out_busy}, '0);
    issue(3'b101, 32'h9ABC_DEF0, 32'h0);
    check("mtlo_busy", {31'b0, out_busy}, '0);
    check("mt_hi", out_hi, 32'h1234_5678);
    check("mt_lo", out_lo, 32'h9ABC_DEF0);
    tick();

    // multu 2x3 with an mtlo attempt while busy
    issue(3'b001, 32'd2, 32'd3);
    tick();
    issue(3'b101, 32'h55, 32'h0);
    wait_idle(n);
    check("ign_lo", out_lo, 32'd6);
    check("ign_hi", out_hi, 32'd0);
    tick();

    // reset on busy cycle 3 of a second op
    issue(3'b001, 32'd9, 32'd9);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", {31'b0, out_busy}, '0);
    check("abort_hi", out_hi, '0);
    check("abort_lo", out_lo, '0);
    repeat (MC + 2) tick();
    check("abort_lo_later", out_lo, '0);

    // maddu 1x1 onto hi=0, lo=FFFFFFFF
    issue(3'b100, 32'h0, 32'h0);
    issue(3'b101, 32'hFFFF_FFFF, 32'h0);
    issue(3'b111, 32'd1, 32'd1);
`ifdef MIPS_MDU_MADD_EN
    wait_idle(n);
    check("maddu_hi", out_hi, 32'd1);
    check("maddu_lo", out_lo, 32'd0);
`else
    check("maddu_off_busy", {31'b0, out_busy}, '0);
    check("maddu_off_hi", out_hi, 32'd0);
    check("maddu_off_lo", out_lo, 32'hFFFF_FFFF);
`endif
    tick();

    // Random ops, including strobes while busy and occasional resets.
    for (int i = 0; i < 1500; i++) begin
      reset    = ($urandom_range(0, 199) == 0);
      in_start = ($urandom_range(0, 2) == 0);
      in_op    = 3'($urandom_range(0, 7));
      in_a     = pick();
      in_b     = pick();
      tick();
    end
    reset = 1'b0; in_start = 1'b0;
    repeat (DC + 2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
